// File: rtl/bitstream_stats.sv
// Sliding-window / block bit statistics over a shifting WORD_SIZE-bit window.
// Latency: window updates on the accepting edge; statistics and stats_valid follow one clock later.
// Backpressure: none; a beat is taken on every edge with in_valid=1.
module bitstream_stats #(
  parameter  int WORD_SIZE = 256,
  parameter  int IN_WIDTH  = 8,
  parameter  int MODE      = 0,
  localparam int DEPTH     = WORD_SIZE / IN_WIDTH,
  localparam int CW        = $clog2(WORD_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [CW-1:0]        run_limit,
  input  logic                 alarm_clr,
  output logic [WORD_SIZE-1:0] window,
  output logic [CW-1:0]        ones,
  output logic [CW-1:0]        transitions,
  output logic [CW-1:0]        max_run_ones,
  output logic [CW-1:0]        max_run_zeros,
  output logic                 stats_valid,
  output logic                 alarm
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam int BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FW-1:0] fill;
  logic [BW-1:0] beat;
  logic          pend;
  logic          full_now;
  logic          full_next;
  logic          beat_wrap;

  logic [CW-1:0] c_ones;
  logic [CW-1:0] c_tr;
  logic [CW-1:0] c_mro;
  logic [CW-1:0] c_mrz;
  logic [CW-1:0] r1;
  logic [CW-1:0] r0;

  assign full_now  = (fill == FW'(DEPTH));
  assign full_next = full_now || (fill == FW'(DEPTH - 1));
  assign beat_wrap = (beat == BW'(DEPTH - 1));

  // Window shift register, fill/beat counters and the pending-valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
      fill   <= '0;
      beat   <= '0;
      pend   <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (in_valid) begin
        window <= (window << IN_WIDTH) | WORD_SIZE'(in_data);
        if (!full_now) fill <= fill + FW'(1);
        beat <= beat_wrap ? '0 : beat + BW'(1);
        // Block mode only marks the beat that closes a block of DEPTH beats
        if (MODE == 0) pend <= full_next;
        else           pend <= full_next && beat_wrap;
      end
    end
  end

  // Population count, transition count and longest runs across the whole window
  always_comb begin
    c_ones = '0;
    c_tr   = '0;
    c_mro  = '0;
    c_mrz  = '0;
    r1     = '0;
    r0     = '0;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (window[i]) begin
        c_ones = c_ones + CW'(1);
        r1     = r1 + CW'(1);
        r0     = '0;
      end else begin
        r0     = r0 + CW'(1);
        r1     = '0;
      end
      if (r1 > c_mro) c_mro = r1;
      if (r0 > c_mrz) c_mrz = r0;
    end
    for (int i = 0; i < WORD_SIZE - 1; i++) begin
      if (window[i] != window[i+1]) c_tr = c_tr + CW'(1);
    end
  end

  // Statistics registered every cycle so they track the held window during gaps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones          <= '0;
      transitions   <= '0;
      max_run_ones  <= '0;
      max_run_zeros <= '0;
      stats_valid   <= 1'b0;
    end else begin
      ones          <= c_ones;
      transitions   <= c_tr;
      max_run_ones  <= c_mro;
      max_run_zeros <= c_mrz;
      stats_valid   <= pend;
    end
  end

  // Sticky alarm judged on the presented statistics; a set beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm <= 1'b0;
    end else if (stats_valid && (max_run_ones > run_limit || max_run_zeros > run_limit)) begin
      alarm <= 1'b1;
    end else if (alarm_clr) begin
      alarm <= 1'b0;
    end
  end

endmodule
